// File: rtl/mpi_parallel_port.sv
// Multi-channel user parallel port on the MPI bus: per-channel output register with
// a delayed write strobe, per-channel input latch, and a pending-strobe status word.
module mpi_parallel_port #(
  parameter int          CHANNELS     = 1,
  parameter logic [15:0] BASE_ADDR    = 16'o177714,
  parameter int          STROBE_DELAY = 1,
  parameter int          STROBE_WIDTH = 2,
  parameter bit          LEGACY_LATCH = 1'b1
) (
  input  logic                    clk,
  input  logic                    nRST,
  input  logic [15:0]             nAD_in,
  output logic [15:0]             nAD_out,
  output logic                    nAD_oe,
  input  logic                    nSYNC,
  input  logic                    nDIN,
  input  logic                    nDOUT,
  input  logic                    nWTBT,
  output logic                    nRPLY,
  input  logic [16*CHANNELS-1:0]  XT_in,
  output logic [16*CHANNELS-1:0]  XT_out,
  output logic [CHANNELS-1:0]     STROBE
);

  localparam int          DW        = $clog2(STROBE_DELAY + 1);
  localparam int          WW        = $clog2(STROBE_WIDTH + 1);
  localparam logic [15:0] BASE_EVEN = {BASE_ADDR[15:1], 1'b0};

  typedef enum logic [2:0] {IDLE, ADDR_LATCH, ARMED, READ, WRITE, WAIT_END} state_t;

  state_t      state_q;
  logic [1:0]  sync_ff_q, din_ff_q, dout_ff_q;
  logic        sync_prev_q, din_prev_q;
  logic [2:0]  sync_vld_q;
  logic        sync_s, din_s, dout_s, sync_fall, din_fall;

  logic        sel_out_q, sel_in_q, sel_stat_q, addr_lsb_q;
  logic [1:0]  sel_ch_q;
  logic        nrply_q, oe_q;
  logic [15:0] nad_out_q;

  logic [15:0] a_in, a_even, rd_data;
  logic        dec_out, dec_in, dec_stat;
  logic [1:0]  dec_ch;
  logic        enter_read, enter_write;

  logic [16*CHANNELS-1:0] out_all, in_all;
  logic [CHANNELS-1:0]    pend, wr_commit, in_load;

  // The synchronisers reset to the idle level; the valid shift register keeps the
  // edge detectors blind until real pin samples have reached the compare stage, so a
  // strobe held low across reset is never mistaken for a fresh falling edge.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      sync_ff_q   <= 2'b11;
      din_ff_q    <= 2'b11;
      dout_ff_q   <= 2'b11;
      sync_prev_q <= 1'b1;
      din_prev_q  <= 1'b1;
      sync_vld_q  <= 3'b000;
    end else begin
      sync_ff_q   <= {sync_ff_q[0], nSYNC};
      din_ff_q    <= {din_ff_q[0], nDIN};
      dout_ff_q   <= {dout_ff_q[0], nDOUT};
      sync_prev_q <= sync_ff_q[1];
      din_prev_q  <= din_ff_q[1];
      sync_vld_q  <= {sync_vld_q[1:0], 1'b1};
    end
  end

  assign sync_s    = sync_ff_q[1];
  assign din_s     = din_ff_q[1];
  assign dout_s    = dout_ff_q[1];
  assign sync_fall = sync_vld_q[2] & sync_prev_q & ~sync_s;
  assign din_fall  = sync_vld_q[2] & din_prev_q & ~din_s;

  assign a_in   = ~nAD_in;
  assign a_even = {a_in[15:1], 1'b0};

  always_comb begin
    dec_out  = 1'b0;
    dec_in   = 1'b0;
    dec_ch   = 2'd0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (a_even == BASE_EVEN + 16'(4 * k)) begin
        dec_out = 1'b1;
        dec_ch  = 2'(k);
      end
      if (a_even == BASE_EVEN + 16'(4 * k + 2)) begin
        dec_in = 1'b1;
        dec_ch = 2'(k);
      end
    end
    dec_stat = (a_even == BASE_EVEN + 16'(4 * CHANNELS));
  end

  assign enter_read  = (state_q == ARMED) && !din_s;
  assign enter_write = (state_q == ARMED) && din_s && !dout_s;

  // A read of an input register that latches this very clock returns the pins directly.
  always_comb begin
    rd_data = 16'h0000;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_ch_q == 2'(k)) begin
        if (sel_out_q) rd_data = out_all[16*k +: 16];
        if (sel_in_q)  rd_data = in_load[k] ? XT_in[16*k +: 16] : in_all[16*k +: 16];
      end
    end
    if (sel_stat_q) rd_data = 16'(pend);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      sel_out_q  <= 1'b0;
      sel_in_q   <= 1'b0;
      sel_stat_q <= 1'b0;
      sel_ch_q   <= 2'd0;
      addr_lsb_q <= 1'b0;
      nrply_q    <= 1'b1;
      oe_q       <= 1'b0;
      nad_out_q  <= 16'hFFFF;
    end else begin
      case (state_q)
        IDLE: if (sync_fall) state_q <= ADDR_LATCH;
        ADDR_LATCH: begin
          sel_out_q  <= dec_out;
          sel_in_q   <= dec_in;
          sel_stat_q <= dec_stat;
          sel_ch_q   <= dec_ch;
          addr_lsb_q <= a_in[0];
          state_q    <= (dec_out || dec_in || dec_stat) ? ARMED : WAIT_END;
        end
        ARMED: begin
          if (!din_s) begin
            nad_out_q <= ~rd_data;
            oe_q      <= 1'b1;
            state_q   <= READ;
          end else if (!dout_s) begin
            state_q <= WRITE;
          end else if (sync_s) begin
            state_q <= IDLE;
          end
        end
        READ: begin
          if (din_s) begin
            nrply_q   <= 1'b1;
            oe_q      <= 1'b0;
            nad_out_q <= 16'hFFFF;
            state_q   <= WAIT_END;
          end else begin
            nrply_q <= 1'b0;
          end
        end
        WRITE: begin
          if (dout_s) begin
            nrply_q <= 1'b1;
            state_q <= WAIT_END;
          end else begin
            nrply_q <= 1'b0;
          end
        end
        WAIT_END: if (sync_s) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign nRPLY   = nrply_q;
  assign nAD_oe  = oe_q;
  assign nAD_out = nad_out_q;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [15:0]   out_q, in_q;
      logic [DW-1:0] dly_q;
      logic [WW-1:0] wid_q;
      logic          stb_q;
      logic          hit;

      assign hit           = (sel_ch_q == 2'(gi));
      assign wr_commit[gi] = enter_write & sel_out_q & hit;
      assign in_load[gi]   = LEGACY_LATCH ? din_fall : (enter_read & sel_in_q & hit);

      // The byte value travels on the low data lines; A[0] picks the destination lane.
      always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
          out_q <= 16'h0000;
          in_q  <= 16'h0000;
          dly_q <= '0;
          wid_q <= '0;
          stb_q <= 1'b0;
        end else begin
          if (wr_commit[gi]) begin
            if (!nWTBT) begin
              if (addr_lsb_q) out_q[15:8] <= a_in[7:0];
              else            out_q[7:0]  <= a_in[7:0];
            end else begin
              out_q <= a_in;
            end
            dly_q <= DW'(STROBE_DELAY);
            wid_q <= '0;
            stb_q <= 1'b0;
          end else if (dly_q != '0) begin
            dly_q <= dly_q - DW'(1);
            if (dly_q == DW'(1)) begin
              stb_q <= 1'b1;
              wid_q <= WW'(STROBE_WIDTH);
            end
          end else if (wid_q != '0) begin
            wid_q <= wid_q - WW'(1);
            if (wid_q == WW'(1)) stb_q <= 1'b0;
          end
          if (in_load[gi]) in_q <= XT_in[16*gi +: 16];
        end
      end

      assign out_all[16*gi +: 16] = out_q;
      assign in_all[16*gi +: 16]  = in_q;
      assign STROBE[gi]           = stb_q;
      assign pend[gi]             = stb_q | (dly_q != '0);
    end
  endgenerate

  assign XT_out = out_all;

endmodule

// File: tb/tb_mpi_parallel_port.sv
// Directed bench: two 2-channel ports share one bus; u1 uses the default strobe timing
// with legacy latching, u3 a long strobe delay with addressed latching.
module tb_mpi_parallel_port;

  localparam int D3 = 40;
  localparam int W3 = 3;

  logic        clk = 1'b0;
  logic        nRST = 1'b1;
  logic [15:0] nAD_in = 16'hFFFF;
  logic        nSYNC = 1'b1, nDIN = 1'b1, nDOUT = 1'b1, nWTBT = 1'b1;
  logic [31:0] XT_in = 32'h0;

  logic [15:0] nad1, nad3;
  logic        oe1, oe3, rply1, rply3;
  logic [31:0] xt1, xt3;
  logic [1:0]  stb1, stb3;

  int n_cmp = 0, n_err = 0, cyc = 0;
  int rise1_n = 0, hi1_n = 0, rise1_cyc = 0, rise3_n = 0, hi3_n = 0, rise3_cyc = 0;
  logic stb1_prev = 1'b0, stb3_prev = 1'b0;

  mpi_parallel_port #(.CHANNELS(2), .BASE_ADDR(16'o177714), .STROBE_DELAY(1),
                      .STROBE_WIDTH(2), .LEGACY_LATCH(1'b1)) u1 (
    .clk(clk), .nRST(nRST), .nAD_in(nAD_in), .nAD_out(nad1), .nAD_oe(oe1),
    .nSYNC(nSYNC), .nDIN(nDIN), .nDOUT(nDOUT), .nWTBT(nWTBT), .nRPLY(rply1),
    .XT_in(XT_in), .XT_out(xt1), .STROBE(stb1));

  mpi_parallel_port #(.CHANNELS(2), .BASE_ADDR(16'o177714), .STROBE_DELAY(D3),
                      .STROBE_WIDTH(W3), .LEGACY_LATCH(1'b0)) u3 (
    .clk(clk), .nRST(nRST), .nAD_in(nAD_in), .nAD_out(nad3), .nAD_oe(oe3),
    .nSYNC(nSYNC), .nDIN(nDIN), .nDOUT(nDOUT), .nWTBT(nWTBT), .nRPLY(rply3),
    .XT_in(XT_in), .XT_out(xt3), .STROBE(stb3));

  always #5 clk = ~clk;

  // Strobe monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (stb1[0] && !stb1_prev) begin rise1_n++; rise1_cyc = cyc; end
    if (stb3[0] && !stb3_prev) begin rise3_n++; rise3_cyc = cyc; end
    if (stb1[0]) hi1_n++;
    if (stb3[0]) hi3_n++;
    stb1_prev = stb1[0];
    stb3_prev = stb3[0];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_mon();
    rise1_n = 0; hi1_n = 0; rise3_n = 0; hi3_n = 0;
  endtask

  task automatic wait_rply(input string tag, input logic lvl, output int n);
    n = 0;
    while (n < 16 && rply1 !== lvl) begin
      tick(1);
      n++;
    end
    chk(tag, {31'd0, rply1}, {31'd0, lvl});
    chk({tag, "_u3"}, {31'd0, rply3}, {31'd0, lvl});
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data,
                           input bit byte_wr, output int dcyc);
    int n;
    nAD_in = ~addr; nSYNC = 1'b0;
    tick(5);
    nAD_in = ~data; nWTBT = ~byte_wr; nDOUT = 1'b0;
    dcyc = cyc;
    wait_rply("wr_reply", 1'b0, n);
    chk("wr_reply_latency", n, 4);
    tick(1);
    nDOUT = 1'b1;
    wait_rply("wr_release", 1'b1, n);
    nSYNC = 1'b1; nWTBT = 1'b1; nAD_in = 16'hFFFF;
    tick(4);
    $display("write addr=%o data=%h byte=%0d", addr, data, byte_wr);
  endtask

  task automatic bus_read(input string tag, input logic [15:0] addr, input logic [15:0] exp1,
                          input logic [15:0] exp3, input bit clr_xt);
    int n, pre;
    logic [15:0] v1, v3;
    pre = 0;
    nAD_in = ~addr; nSYNC = 1'b0;
    tick(5);
    nAD_in = 16'hFFFF; nDIN = 1'b0;
    if (clr_xt) begin
      tick(3);
      pre = 3;
      XT_in = 32'h0;
    end
    wait_rply({tag, "_reply"}, 1'b0, n);
    chk({tag, "_latency"}, n + pre, 4);
    v1 = ~nad1;
    v3 = ~nad3;
    chk({tag, "_data"}, {16'd0, v1}, {16'd0, exp1});
    chk({tag, "_data_u3"}, {16'd0, v3}, {16'd0, exp3});
    chk({tag, "_oe"}, {31'd0, oe1}, 32'd1);
    tick(1);
    nDIN = 1'b1;
    wait_rply({tag, "_release"}, 1'b1, n);
    chk({tag, "_oe_off"}, {30'd0, oe3, oe1}, 32'd0);
    nSYNC = 1'b1;
    tick(4);
    $display("read  addr=%o data=%h/%h", addr, v1, v3);
  endtask

  initial begin
    int d, d2, n;
    #2 nRST = 1'b0;
    tick(3);
    chk("rst_nrply", {30'd0, rply3, rply1}, 32'h3);
    chk("rst_oe", {30'd0, oe3, oe1}, 32'h0);
    chk("rst_nad_out", {16'd0, nad1}, 32'h0000_FFFF);
    chk("rst_xt_out", xt1 | xt3, 32'h0);
    chk("rst_strobe", {28'd0, stb3, stb1}, 32'h0);
    nRST = 1'b1;
    tick(6);

    // Word write to OUT0, strobe one clock after the commit, two clocks wide
    clr_mon();
    bus_write(16'o177714, 16'h1234, 1'b0, d);
    chk("wr_out", xt1, 32'h0000_1234);
    chk("wr_out_u3", xt3, 32'h0000_1234);
    chk("wr_stb_count", rise1_n, 1);
    chk("wr_stb_start", rise1_cyc, d + 4);
    chk("wr_stb_width", hi1_n, 2);

    // Read IN1
    XT_in = 32'hA5C3_0000;
    bus_read("rd_in1", 16'o177722, 16'hA5C3, 16'hA5C3, 1'b0);

    // Unmapped read: no reply; then IN0 read returns the latched value, not the pins
    XT_in = 32'h0000_0F0F;
    nAD_in = ~16'o177600; nSYNC = 1'b0;
    tick(5);
    nAD_in = 16'hFFFF; nDIN = 1'b0;
    tick(10);
    chk("unmapped_no_reply", {30'd0, rply3, rply1}, 32'h3);
    nDIN = 1'b1; nSYNC = 1'b1;
    tick(4);
    $display("read  addr=%o unmapped", 16'o177600);
    bus_read("rd_in0", 16'o177716, 16'h0F0F, 16'h0F0F, 1'b1);

    // Byte writes into each lane, then channel 1 and a write to read-only IN1
    bus_write(16'o177714, 16'hFFFF, 1'b0, d);
    clr_mon();
    bus_write(16'o177715, 16'h00AA, 1'b1, d);
    chk("byte_hi", {16'd0, xt1[15:0]}, 32'h0000_AAFF);
    chk("byte_hi_u3", {16'd0, xt3[15:0]}, 32'h0000_AAFF);
    chk("byte_stb", rise1_n, 1);
    bus_write(16'o177714, 16'h5555, 1'b1, d);
    chk("byte_lo", {16'd0, xt1[15:0]}, 32'h0000_AA55);
    bus_read("rd_out0", 16'o177714, 16'hAA55, 16'hAA55, 1'b0);
    bus_write(16'o177720, 16'hBEEF, 1'b0, d);
    chk("wr_out1", xt1, 32'hBEEF_AA55);
    bus_write(16'o177722, 16'h1111, 1'b0, d);
    chk("wr_in1_ignored", xt1, 32'hBEEF_AA55);

    // Back-to-back writes restart the long strobe delay of u3
    tick(60);
    clr_mon();
    bus_write(16'o177714, 16'h0001, 1'b0, d);
    bus_write(16'o177714, 16'h0002, 1'b0, d2);
    bus_read("rd_status", 16'o177724, 16'h0000, 16'h0001, 1'b0);
    while (cyc < d2 + 3 + D3 + W3 + 2) tick(1);
    chk("b2b_u1_pulses", rise1_n, 2);
    chk("b2b_pulses", rise3_n, 1);
    chk("b2b_start", rise3_cyc, d2 + 3 + D3);
    chk("b2b_width", hi3_n, W3);

    // Reset in the middle of a replied read
    nAD_in = ~16'o177714; nSYNC = 1'b0;
    tick(5);
    nAD_in = 16'hFFFF; nDIN = 1'b0;
    wait_rply("rst_pre_reply", 1'b0, n);
    nRST = 1'b0;
    #1;
    chk("rst_mid_nrply", {30'd0, rply3, rply1}, 32'h3);
    chk("rst_mid_oe", {30'd0, oe3, oe1}, 32'h0);
    chk("rst_mid_xt", xt1 | xt3, 32'h0);
    @(negedge clk);
    nRST = 1'b1;
    tick(10);
    chk("rst_no_reply", {30'd0, rply3, rply1}, 32'h3);
    nDIN = 1'b1; nSYNC = 1'b1;
    tick(4);
    $display("reset during read of %o", 16'o177714);
    bus_read("rd_after_rst", 16'o177714, 16'h0000, 16'h0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
